mfcc_melbank_apply: RTL and testbench
=====================================

# mfcc_melbank_apply

Applies the 20-band mel triangular filterbank to one 256-bin power spectrum per frame. Drives the address port of the combinational 512×8 mel-weight ROM (zero read latency, 9-bit addr, 8-bit data), multiplies each incoming spectrum bin by its two overlapping filter weights, and emits 20 accumulated band energies. Sits between the FFT power stage and the log/DCT stage of the MFCC chain.

## Interface
- DIN_W, 32, unsigned power-spectrum sample width
- ACC_W, 48, per-filter accumulator width (≥ DIN_W+8+8)
- OUT_W, 32, band-energy output width
- NFILT, 20, number of mel filters (fixed by ROM contents)
- clk  in  1  sole clock, all logic rising-edge
- rst  in  1  synchronous, active-high reset
- rom_addr  out  9  ROM address; reset 9'h100
- rom_data  in  8  ROM data, valid same cycle as rom_addr
- s_valid  in  1  spectrum sample valid
- s_ready  out  1  spectrum sample accept; reset 0
- s_data  in  DIN_W  bin power, bins 0..255 in order
- s_last  in  1  last bin of frame
- m_valid  out  1  band energy valid; reset 0
- m_ready  in  1  downstream accept
- m_data  out  OUT_W  band energy; reset 0
- m_index  out  5  filter number 0..19; reset 0
- m_last  out  1  high with filter 19; reset 0
- frame_err  out  1  one-cycle pulse on frame-length mismatch; reset 0

## Operation
- ROM layout: addr {0,b} = weight w(b), Q0.8 rising-slope weight for filter f(b); addr {1,b} = f(b) in rom_data[4:0], f ∈ 0..21 (filter numbers 1..20 map to accumulators 0..19).
- Per bin b: rising contribution s·w to filter f; falling contribution s·(256−w) to filter f−1. Targets 0 or 21 discarded; f>21 discards both.
- FSM states: IDX, WGT, DRAIN, OUT, CLR.
  - IDX: rom_addr={1,b}; latch f; → WGT next cycle.
  - WGT: rom_addr={0,b}; s_ready=1; on s_valid: register both products (DIN_W+9 bits) and targets, b←b+1; if b==255 or s_last → DRAIN, else → IDX. No s_valid: hold.
  - DRAIN: final product pair added to accumulators; → OUT.
  - OUT: present accumulator m_index; advance on m_valid&&m_ready; after index 19 accepted → CLR.
  - CLR: zero all accumulators and b; → IDX.
- Accumulate stage runs one cycle after each accepted bin (pipelined, overlaps next IDX); both targets of one bin are always distinct filters.
- Accumulators wrap modulo 2^ACC_W (cannot overflow for legal data).
- frame_err pulses in DRAIN entry if s_last and b==255 disagree; frame closes either way; unreceived bins contribute zero.

## Timing
- Throughput: 2 cycles/bin minimum; full frame 512 cycles + 1 DRAIN + ≥20 OUT + 1 CLR.
- First m_valid 2 cycles after the accepting s_valid of the last bin.
- m_valid/m_data/m_index/m_last stable while m_valid && !m_ready.
- s_ready low in every state except WGT; no samples accepted during OUT.
- rst mid-frame or mid-output: next cycle all outputs at reset values, accumulators and b cleared, FSM in IDX.

## Configuration
- MELBANK_SAT_EN defined: m_data = acc[OUT_W+7:8], saturated to 2^OUT_W−1 when any of acc[ACC_W-1:OUT_W+8] is set.
- Not defined: m_data = acc[OUT_W+7:8], upper bits discarded (truncation).

## Test plan
- ROM all weights 128, f(b)=b/12+1, s_data=1000 every bin, no backpressure -> 20 outputs, indices 0..19 in order, m_last on 19, each value equals model (1000·128·binsPerFilter)>>8.
- Single nonzero bin b=40 (s=2^20, w=64, f=4) -> m_data[3]=2^18, m_data[2]=3·2^18, all others 0.
- m_ready toggled 1-of-3 during OUT -> outputs held stable while stalled, no value lost or duplicated, s_ready stays 0.
- s_last asserted at bin 100 -> frame_err one-cycle pulse, outputs reflect bins 0..100 only, next frame starts at bin 0.
- s_data=2^32−1, w=255 on all bins to one filter, MELBANK_SAT_EN defined -> m_data=32'hFFFF_FFFF; undefined -> truncated value acc[39:8].
- rst asserted at bin 130 then new frame -> no frame_err, outputs match clean-frame model.

Source files
------------

// File: rtl/mfcc_melbank_apply.sv
// Mel triangular filterbank: each power bin feeds the rising slope of filter f(b) and the falling slope of f(b)-1.
// Optional macro MELBANK_SAT_EN: saturate band energies to all-ones instead of truncating the upper accumulator bits.
module mfcc_melbank_apply #(
    parameter int DIN_W = 32,
    parameter int ACC_W = 48,
    parameter int OUT_W = 32,
    parameter int NFILT = 20
) (
    input  logic             clk,
    input  logic             rst,
    output logic [8:0]       rom_addr,
    input  logic [7:0]       rom_data,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [DIN_W-1:0] s_data,
    input  logic             s_last,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [OUT_W-1:0] m_data,
    output logic [4:0]       m_index,
    output logic             m_last,
    output logic             frame_err
);
    localparam int         PW         = DIN_W + 9;
    localparam logic [4:0] L_LAST_IDX = 5'(NFILT - 1);
    localparam logic [4:0] L_PRE_LAST = 5'(NFILT - 2);
    localparam logic [4:0] L_MAX_RISE = 5'(NFILT);
    localparam logic [4:0] L_MAX_FALL = 5'(NFILT + 1);

    typedef enum logic [2:0] {IDX, WGT, DRAIN, OUT, CLR} state_t;

    state_t           r_state;
    logic [7:0]       r_bin;
    logic [4:0]       r_filt;
    logic [8:0]       r_rom_addr;
    logic             r_s_ready;
    logic             r_m_valid;
    logic             r_m_last;
    logic             r_frame_err;
    logic [4:0]       r_out_idx;
    logic             r_pend;
    logic             r_rise_en;
    logic             r_fall_en;
    logic [4:0]       r_tgt_rise;
    logic [4:0]       r_tgt_fall;
    logic [PW-1:0]    r_prod_rise;
    logic [PW-1:0]    r_prod_fall;

    logic [PW-1:0]    w_s_ext;
    logic [PW-1:0]    w_w_rise;
    logic [PW-1:0]    w_w_fall;
    logic [PW-1:0]    w_prod_rise;
    logic [PW-1:0]    w_prod_fall;
    logic             w_rise_ok;
    logic             w_fall_ok;
    logic             w_last_bin;
    logic [NFILT*ACC_W-1:0] w_acc_flat;
    logic [ACC_W-1:0] w_sel;
    logic             w_sel_unused;

    // Falling weight is 256-w, so a zero rising weight gives a full-scale 9-bit falling weight.
    assign w_s_ext     = {9'd0, s_data};
    assign w_w_rise    = {{DIN_W{1'b0}}, 1'b0, rom_data};
    assign w_w_fall    = {{DIN_W{1'b0}}, 9'd256 - {1'b0, rom_data}};
    assign w_prod_rise = w_s_ext * w_w_rise;
    assign w_prod_fall = w_s_ext * w_w_fall;

    // Filter numbers 0 and NFILT+1 are the edge guards of the bank and are never accumulated.
    assign w_rise_ok  = (r_filt != 5'd0) && (r_filt <= L_MAX_RISE);
    assign w_fall_ok  = (r_filt >= 5'd2) && (r_filt <= L_MAX_FALL);
    assign w_last_bin = (r_bin == 8'hFF);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDX;
            r_bin       <= '0;
            r_filt      <= '0;
            r_rom_addr  <= 9'h100;
            r_s_ready   <= 1'b0;
            r_m_valid   <= 1'b0;
            r_m_last    <= 1'b0;
            r_frame_err <= 1'b0;
            r_out_idx   <= '0;
            r_pend      <= 1'b0;
            r_rise_en   <= 1'b0;
            r_fall_en   <= 1'b0;
            r_tgt_rise  <= '0;
            r_tgt_fall  <= '0;
            r_prod_rise <= '0;
            r_prod_fall <= '0;
        end else begin
            r_frame_err <= 1'b0;
            r_pend      <= 1'b0;
            case (r_state)
                IDX: begin
                    r_filt     <= rom_data[4:0];
                    r_rom_addr <= {1'b0, r_bin};
                    r_s_ready  <= 1'b1;
                    r_state    <= WGT;
                end
                WGT: begin
                    if (s_valid) begin
                        r_prod_rise <= w_prod_rise;
                        r_prod_fall <= w_prod_fall;
                        r_rise_en   <= w_rise_ok;
                        r_fall_en   <= w_fall_ok;
                        r_tgt_rise  <= r_filt - 5'd1;
                        r_tgt_fall  <= r_filt - 5'd2;
                        r_pend      <= 1'b1;
                        r_s_ready   <= 1'b0;
                        r_bin       <= r_bin + 8'd1;
                        if (w_last_bin || s_last) begin
                            r_frame_err <= s_last != w_last_bin;
                            r_state     <= DRAIN;
                        end else begin
                            r_rom_addr <= {1'b1, r_bin + 8'd1};
                            r_state    <= IDX;
                        end
                    end
                end
                DRAIN: begin
                    r_m_valid <= 1'b1;
                    r_m_last  <= 1'b0;
                    r_out_idx <= '0;
                    r_state   <= OUT;
                end
                OUT: begin
                    if (m_ready) begin
                        if (r_out_idx == L_LAST_IDX) begin
                            r_m_valid <= 1'b0;
                            r_m_last  <= 1'b0;
                            r_out_idx <= '0;
                            r_state   <= CLR;
                        end else begin
                            r_out_idx <= r_out_idx + 5'd1;
                            r_m_last  <= (r_out_idx == L_PRE_LAST);
                        end
                    end
                end
                CLR: begin
                    r_bin      <= '0;
                    r_rom_addr <= 9'h100;
                    r_state    <= IDX;
                end
                default: begin
                    r_state <= IDX;
                end
            endcase
        end
    end

    // The two targets of one bin are always distinct filters, so each accumulator sees at most one addend.
    generate
        for (genvar gi = 0; gi < NFILT; gi++) begin : g_acc
            logic [ACC_W-1:0] r_acc;
            logic [ACC_W-1:0] w_add_rise;
            logic [ACC_W-1:0] w_add_fall;

            assign w_add_rise = (r_rise_en && (r_tgt_rise == 5'(gi))) ?
                                {{(ACC_W-PW){1'b0}}, r_prod_rise} : '0;
            assign w_add_fall = (r_fall_en && (r_tgt_fall == 5'(gi))) ?
                                {{(ACC_W-PW){1'b0}}, r_prod_fall} : '0;

            always_ff @(posedge clk) begin
                if (rst || (r_state == CLR)) begin
                    r_acc <= '0;
                end else if (r_pend) begin
                    r_acc <= r_acc + w_add_rise + w_add_fall;
                end
            end

            assign w_acc_flat[gi*ACC_W +: ACC_W] = r_acc;
        end
    endgenerate

    assign w_sel = w_acc_flat[r_out_idx*ACC_W +: ACC_W];

`ifdef MELBANK_SAT_EN
    assign m_data = (|w_sel[ACC_W-1:OUT_W+8]) ? {OUT_W{1'b1}} : w_sel[OUT_W+7:8];
`else
    assign m_data = w_sel[OUT_W+7:8];
`endif
    assign w_sel_unused = ^{w_sel[ACC_W-1:OUT_W+8], w_sel[7:0]};

    assign rom_addr  = r_rom_addr;
    assign s_ready   = r_s_ready;
    assign m_valid   = r_m_valid;
    assign m_index   = r_out_idx;
    assign m_last    = r_m_last;
    assign frame_err = r_frame_err;

endmodule

// File: tb/tb_mfcc_melbank_apply.sv
// Randomized bench for mfcc_melbank_apply with a combinational ROM model and a per-bin arithmetic reference.
module tb_mfcc_melbank_apply;
    localparam int DIN_W = 32;
    localparam int ACC_W = 48;
    localparam int OUT_W = 32;
    localparam int NFILT = 20;

    logic             clk = 1'b0;
    logic             rst;
    logic [8:0]       rom_addr;
    logic [7:0]       rom_data;
    logic             s_valid;
    logic             s_ready;
    logic [DIN_W-1:0] s_data;
    logic             s_last;
    logic             m_valid;
    logic             m_ready;
    logic [OUT_W-1:0] m_data;
    logic [4:0]       m_index;
    logic             m_last;
    logic             frame_err;

    logic [7:0]  rom [512];
    logic [31:0] din [256];
    logic [31:0] exp_val [NFILT];
    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;
    assign rom_data = rom[rom_addr];

    mfcc_melbank_apply #(
        .DIN_W(DIN_W), .ACC_W(ACC_W), .OUT_W(OUT_W), .NFILT(NFILT)
    ) dut (
        .clk(clk), .rst(rst), .rom_addr(rom_addr), .rom_data(rom_data),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_index(m_index),
        .m_last(m_last), .frame_err(frame_err)
    );

    // Reference: every received bin adds s*w to filter f and s*(256-w) to filter f-1.
    task automatic build_model(input int last_bin);
        logic [47:0] acc [NFILT];
        for (int i = 0; i < NFILT; i++) acc[i] = '0;
        for (int b = 0; b <= last_bin; b++) begin
            int f;
            int w;
            logic [47:0] s;
            f = int'(rom[256+b][4:0]);
            w = int'(rom[b]);
            s = 48'(din[b]);
            if (f >= 1 && f <= NFILT)     acc[f-1] = acc[f-1] + s * 48'(w);
            if (f >= 2 && f <= NFILT + 1) acc[f-2] = acc[f-2] + s * 48'(256 - w);
        end
        for (int i = 0; i < NFILT; i++) begin
`ifdef MELBANK_SAT_EN
            if ((acc[i] >> 40) != 48'd0) exp_val[i] = 32'hFFFF_FFFF;
            else                         exp_val[i] = 32'(acc[i] >> 8);
`else
            exp_val[i] = 32'(acc[i] >> 8);
`endif
        end
    endtask

    task automatic load_rom_random();
        for (int b = 0; b < 256; b++) begin
            rom[b]     = 8'($urandom_range(0, 255));
            rom[256+b] = {3'($urandom_range(0, 7)), 5'($urandom_range(0, 23))};
        end
    endtask

    task automatic load_din_random();
        for (int b = 0; b < 256; b++) din[b] = $urandom;
    endtask

    task automatic do_reset();
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_data  = '0;
        m_ready = 1'b0;
        rst     = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Streams bins 0..last_bin, collects 20 outputs and checks order, values, stalls, latency and frame_err.
    task automatic run_frame(input int last_bin, input int valid_pct, input bit stall, input string tag);
        int next_bin = 0;
        int outs = 0;
        int cyc = 0;
        int last_acc_cyc = -1;
        int first_mv_cyc = -1;
        int ferr_cycles = 0;
        bit held = 1'b0;
        logic [31:0] h_data;
        logic [4:0]  h_index;
        logic        h_last;
        while (outs < NFILT && cyc < 4000) begin
            @(negedge clk);
            if (frame_err === 1'b1) ferr_cycles++;
            if (held) begin
                n_checks++;
                if (m_valid !== 1'b1 || m_data !== h_data || m_index !== h_index || m_last !== h_last) begin
                    n_fail++;
                    $display("FAIL %s stall_hold: got v=%b d=%0h i=%0d l=%b required v=1 d=%0h i=%0d l=%b",
                             tag, m_valid, m_data, m_index, m_last, h_data, h_index, h_last);
                end
            end
            s_valid = (next_bin <= last_bin) && ($urandom_range(0, 99) < valid_pct);
            s_data  = (s_valid && next_bin < 256) ? din[next_bin] : $urandom;
            s_last  = s_valid && (next_bin == last_bin);
            m_ready = stall ? (cyc % 3 == 2) : 1'b1;
            if (m_valid === 1'b1) begin
                n_checks++;
                if (s_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s s_ready_in_out: got %b required 0", tag, s_ready);
                end
            end
            if (s_valid && s_ready === 1'b1) begin
                last_acc_cyc = cyc;
                next_bin++;
            end
            if (m_valid === 1'b1 && first_mv_cyc < 0) first_mv_cyc = cyc;
            if (m_valid === 1'b1 && m_ready) begin
                n_checks++;
                if (m_data !== exp_val[outs] || m_index !== 5'(outs) || m_last !== (outs == NFILT - 1)) begin
                    n_fail++;
                    $display("FAIL %s band%0d: got d=%0h i=%0d l=%b required d=%0h i=%0d l=%b",
                             tag, outs, m_data, m_index, m_last, exp_val[outs], outs, (outs == NFILT - 1));
                end
                outs++;
                held = 1'b0;
            end else if (m_valid === 1'b1) begin
                held    = 1'b1;
                h_data  = m_data;
                h_index = m_index;
                h_last  = m_last;
            end else begin
                held = 1'b0;
            end
            cyc++;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        n_checks++;
        if (outs != NFILT) begin
            n_fail++;
            $display("FAIL %s timeout: got %0d outputs required %0d", tag, outs, NFILT);
        end
        n_checks++;
        if (first_mv_cyc - last_acc_cyc != 2) begin
            n_fail++;
            $display("FAIL %s latency: got %0d cycles required 2", tag, first_mv_cyc - last_acc_cyc);
        end
        n_checks++;
        if (ferr_cycles != ((last_bin != 255) ? 1 : 0)) begin
            n_fail++;
            $display("FAIL %s frame_err_cycles: got %0d required %0d", tag, ferr_cycles, (last_bin != 255) ? 1 : 0);
        end
        $display("frame %s: bins 0..%0d, %0d outputs, frame_err cycles %0d", tag, last_bin, outs, ferr_cycles);
    endtask

    task automatic check_reset_values(input string tag);
        n_checks++;
        if (rom_addr !== 9'h100 || s_ready !== 1'b0 || m_valid !== 1'b0 || m_data !== '0 ||
            m_index !== 5'd0 || m_last !== 1'b0 || frame_err !== 1'b0) begin
            n_fail++;
            $display("FAIL %s reset_values: got addr=%0h rdy=%b mv=%b d=%0h i=%0d l=%b fe=%b required addr=100 rest 0",
                     tag, rom_addr, s_ready, m_valid, m_data, m_index, m_last, frame_err);
        end
        $display("reset check %s: addr=%0h s_ready=%b m_valid=%b", tag, rom_addr, s_ready, m_valid);
    endtask

    task automatic test_reset();
        do_reset();
        check_reset_values("reset");
    endtask

    task automatic test_uniform();
        for (int b = 0; b < 256; b++) begin
            rom[b]     = 8'd128;
            rom[256+b] = 8'(b / 12 + 1);
            din[b]     = 32'd1000;
        end
        // Each filter collects 12 rising and 12 falling bins at weight 128: 24*1000*128/256.
        for (int i = 0; i < NFILT; i++) exp_val[i] = 32'd12000;
        do_reset();
        run_frame(255, 100, 1'b0, "uniform");
    endtask

    task automatic test_single_bin();
        for (int b = 0; b < 256; b++) begin
            rom[b]     = 8'd64;
            rom[256+b] = 8'(b / 12 + 1);
            din[b]     = '0;
        end
        din[40] = 32'h0010_0000;
        for (int i = 0; i < NFILT; i++) exp_val[i] = '0;
        exp_val[3] = 32'h0004_0000;
        exp_val[2] = 32'h000C_0000;
        do_reset();
        run_frame(255, 100, 1'b0, "single_bin");
    endtask

    task automatic test_backpressure();
        load_rom_random();
        load_din_random();
        build_model(255);
        do_reset();
        run_frame(255, 70, 1'b1, "backpressure");
    endtask

    task automatic test_short_frame();
        load_rom_random();
        load_din_random();
        build_model(100);
        do_reset();
        run_frame(100, 80, 1'b0, "short_frame");
        load_din_random();
        build_model(255);
        run_frame(255, 90, 1'b0, "after_short");
    endtask

    task automatic test_saturate();
        for (int b = 0; b < 256; b++) begin
            rom[b]     = 8'd255;
            rom[256+b] = 8'd5;
            din[b]     = 32'hFFFF_FFFF;
        end
        build_model(255);
        do_reset();
        run_frame(255, 100, 1'b0, "saturate");
    endtask

    task automatic test_reset_mid_frame();
        int next_bin = 0;
        int cyc = 0;
        load_rom_random();
        load_din_random();
        do_reset();
        while (next_bin <= 130 && cyc < 2000) begin
            @(negedge clk);
            s_valid = ($urandom_range(0, 99) < 80);
            s_data  = din[next_bin];
            s_last  = 1'b0;
            m_ready = 1'b1;
            if (s_valid && s_ready === 1'b1) next_bin++;
            cyc++;
        end
        n_checks++;
        if (next_bin != 131) begin
            n_fail++;
            $display("FAIL mid_reset accept_timeout: got %0d bins required 131", next_bin);
        end
        @(negedge clk);
        s_valid = 1'b0;
        rst     = 1'b1;
        @(negedge clk);
        check_reset_values("mid_frame");
        rst = 1'b0;
        load_din_random();
        build_model(255);
        run_frame(255, 85, 1'b0, "after_mid_reset");
    endtask

    task automatic test_back_to_back();
        load_rom_random();
        do_reset();
        for (int k = 0; k < 2; k++) begin
            load_din_random();
            build_model(255);
            run_frame(255, 100, 1'b0, "back_to_back");
        end
    endtask

    initial begin
        rst     = 1'b1;
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_data  = '0;
        m_ready = 1'b0;
        for (int b = 0; b < 512; b++) rom[b] = '0;
        test_reset();
        test_uniform();
        test_single_bin();
        test_backpressure();
        test_short_frame();
        test_saturate();
        test_reset_mid_frame();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
